// File: rtl/bcd_xs3_seq_conv.sv
// Multi-digit BCD <-> Excess-3 converter.
// One 4-bit digit is converted per clock, least-significant digit first.
// Invalid digits produce 4'hF and set their bit in out_err; conversion
// always runs to completion. Valid/ready handshakes on both sides.
module bcd_xs3_seq_conv #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_data,
    input  logic                  in_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_data,
    output logic [DIGITS-1:0]     out_err
);

    localparam int unsigned        W     = 4 * DIGITS;
    localparam int unsigned        CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0]   LAST  = CNT_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       work_q,  work_d;
    logic [DIGITS-1:0]  err_q,   err_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               mode_q,  mode_d;

    logic [3:0]         cur_digit;
    logic [3:0]         conv_res;
    logic               conv_bad;

    // Convert the digit sitting at the bottom of the work register.
    always_comb begin
        cur_digit = work_q[3:0];
        conv_bad  = 1'b0;
        conv_res  = 4'h0;
        if (!mode_q) begin
            conv_bad = (cur_digit > 4'd9);
            conv_res = cur_digit + 4'd3;
        end else begin
            conv_bad = (cur_digit < 4'd3) || (cur_digit > 4'd12);
            conv_res = cur_digit - 4'd3;
        end
        if (conv_bad) begin
            conv_res = 4'hF;
        end
    end

    // Next-state and datapath update: load on accept, shift/convert in CONV,
    // hold in DONE until the result is taken.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    work_d  = in_data;
                    mode_d  = in_mode;
                    cnt_d   = '0;
                    err_d   = '0;
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                // Result enters at the top; after DIGITS shifts digit 0 is back at [3:0].
                work_d           = work_q >> 4;
                work_d[W-1 -: 4] = conv_res;
                for (int unsigned i = 0; i < DIGITS; i++) begin
                    if (conv_bad && (cnt_q == CNT_W'(i))) begin
                        err_d[i] = 1'b1;
                    end
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: work word, error mask, digit counter, latched mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q <= '0;
            err_q  <= '0;
            cnt_q  <= '0;
            mode_q <= 1'b0;
        end else begin
            work_q <= work_d;
            err_q  <= err_d;
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out_data  = work_q;
    assign out_err   = err_q;

endmodule
